// File: rtl/LOAD_STORE_FNS.sv
// Load/store access size and sign encodings shared by the LSU, the memory and the arbiter.
package LOAD_STORE_FNS;

  typedef enum logic [2:0] {
    BYTE   = 3'b000,
    HALF   = 3'b001,
    WORD   = 3'b010,
    BYTE_U = 3'b100,
    HALF_U = 3'b101
  } funct3_t;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// Types shared by the IF/LS memory arbiter: FSM states, requester IDs and the latched request.
package mem_arbiter_pkg;
  import LOAD_STORE_FNS::*;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic             wren;
    logic [WIDTH-1:0] wr_data;
    funct3_t          funct3;
    req_id_e          owner;
  } req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes, responses and the memory port of the IF/LS arbiter.
interface mem_arbiter_if;
  import LOAD_STORE_FNS::*;
  import mem_arbiter_pkg::*;

  logic             if_req_valid;
  logic             if_req_ready;
  logic [WIDTH-1:0] if_addr;
  logic             if_rsp_valid;
  logic [WIDTH-1:0] if_rsp_data;

  logic             ls_req_valid;
  logic             ls_req_ready;
  logic [WIDTH-1:0] ls_addr;
  logic             ls_wren;
  logic [WIDTH-1:0] ls_wr_data;
  funct3_t          ls_funct3;
  logic             ls_rsp_valid;
  logic [WIDTH-1:0] ls_rsp_data;

  logic [WIDTH-1:0] mem_addr;
  logic             mem_wren;
  logic [WIDTH-1:0] mem_wr_data;
  funct3_t          mem_funct3;
  logic [WIDTH-1:0] mem_rd_data;

  logic             busy;

  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_addr, ls_wren, ls_wr_data, ls_funct3,
    input  mem_rd_data,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_addr, mem_wren, mem_wr_data, mem_funct3,
    output busy
  );

  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_addr, ls_wren, ls_wr_data, ls_funct3,
    output mem_rd_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_addr, mem_wren, mem_wr_data, mem_funct3,
    input  busy
  );

endinterface

// File: rtl/mem_arb_picker.sv
// Combinational grant between IF and LS. MEM_ARBITER_ROUND_ROBIN_EN selects round-robin
// with a last_grant register; otherwise LS has fixed priority over IF.
module mem_arb_picker
  import mem_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic idle_i,
  input  logic if_valid_i,
  input  logic ls_valid_i,
  output logic if_ready_c,
  output logic ls_ready_c
);

  logic open_c;
  assign open_c = idle_i && !rst_i;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  req_id_e last_grant_q, last_grant_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) last_grant_q <= REQ_IF;
    else       last_grant_q <= last_grant_d;
  end

  // On a tie the requester not granted last time wins.
  always_comb begin
    if_ready_c   = 1'b0;
    ls_ready_c   = 1'b0;
    last_grant_d = last_grant_q;
    if (open_c) begin
      if (if_valid_i && ls_valid_i) begin
        if (last_grant_q == REQ_IF) ls_ready_c = 1'b1;
        else                        if_ready_c = 1'b1;
      end else begin
        if_ready_c = if_valid_i;
        ls_ready_c = ls_valid_i;
      end
    end
    if (ls_ready_c)      last_grant_d = REQ_LS;
    else if (if_ready_c) last_grant_d = REQ_IF;
  end
`else
  logic unused_clk;
  assign unused_clk = clk_i;

  always_comb begin
    ls_ready_c = open_c && ls_valid_i;
    if_ready_c = open_c && if_valid_i && !ls_valid_i;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the unified memory port between fetch and load/store: accept, issue one cycle, respond.
// Optional round-robin arbitration via MEM_ARBITER_ROUND_ROBIN_EN (see mem_arb_picker).
module mem_arbiter
  import LOAD_STORE_FNS::*;
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_e state_q, state_d;
  req_t   req_q, req_d;
  logic   if_ready_c, ls_ready_c;

  mem_arb_picker u_picker (
    .clk_i      (clk),
    .rst_i      (rst),
    .idle_i     (state_q == IDLE),
    .if_valid_i (bus.if_req_valid),
    .ls_valid_i (bus.ls_req_valid),
    .if_ready_c (if_ready_c),
    .ls_ready_c (ls_ready_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Fetches are always word reads; the latch holds the request through ISSUE and RESP.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (ls_ready_c) begin
          req_d = '{addr: bus.ls_addr, wren: bus.ls_wren, wr_data: bus.ls_wr_data,
                    funct3: bus.ls_funct3, owner: REQ_LS};
          state_d = ISSUE;
        end else if (if_ready_c) begin
          req_d = '{addr: bus.if_addr, wren: 1'b0, wr_data: WIDTH'(0),
                    funct3: WORD, owner: REQ_IF};
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic resp_c, if_rsp_c, ls_rsp_c;
  assign resp_c   = (state_q == RESP) && !rst;
  assign if_rsp_c = resp_c && (req_q.owner == REQ_IF);
  assign ls_rsp_c = resp_c && (req_q.owner == REQ_LS);

  assign bus.if_req_ready = if_ready_c;
  assign bus.ls_req_ready = ls_ready_c;

  assign bus.if_rsp_valid = if_rsp_c;
  assign bus.if_rsp_data  = if_rsp_c ? bus.mem_rd_data : WIDTH'(0);
  assign bus.ls_rsp_valid = ls_rsp_c;
  assign bus.ls_rsp_data  = (ls_rsp_c && !req_q.wren) ? bus.mem_rd_data : WIDTH'(0);

  // Reset kills a store still in ISSUE before the memory can commit it.
  assign bus.mem_wren    = (state_q == ISSUE) && req_q.wren && !rst;
  assign bus.mem_addr    = req_q.addr;
  assign bus.mem_wr_data = req_q.wr_data;
  assign bus.mem_funct3  = req_q.funct3;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a word-addressed memory model behind the port.
module tb_mem_arbiter;
  import LOAD_STORE_FNS::*;
  import mem_arbiter_pkg::*;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic mem_init = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory: commits on the edge ending ISSUE, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[0] <= 32'd12345;
      mem[3] <= 32'h1111_2222;
      bus.mem_rd_data <= '0;
    end else begin
      if (bus.mem_wren) mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
      bus.mem_rd_data <= mem[bus.mem_addr[7:2]];
    end
  end

  task automatic drive_idle();
    bus.if_req_valid = 1'b0;
    bus.if_addr      = '0;
    bus.ls_req_valid = 1'b0;
    bus.ls_addr      = '0;
    bus.ls_wren      = 1'b0;
    bus.ls_wr_data   = '0;
    bus.ls_funct3    = WORD;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ls_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input funct3_t f, output logic [31:0] rd, output bit ok);
    bit acc;
    acc = 1'b0;
    ok  = 1'b0;
    rd  = '0;
    bus.ls_req_valid = 1'b1;
    bus.ls_addr      = a;
    bus.ls_wren      = w;
    bus.ls_wr_data   = d;
    bus.ls_funct3    = f;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = bus.ls_req_ready;
    end
    step();
    drive_idle();
    if (acc) begin
      for (int i = 0; i < 4 && !ok; i++) begin
        @(negedge clk);
        if (bus.ls_rsp_valid) begin
          ok = 1'b1;
          rd = bus.ls_rsp_data;
        end
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_init = 1'b1;
    drive_idle();
    bus.if_req_valid = 1'b1;
    bus.ls_req_valid = 1'b1;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (bus.if_req_ready !== 1'b0 || bus.ls_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got if=%b ls=%b expected 0 0", bus.if_req_ready, bus.ls_req_ready);
    end
    n_checks++;
    if (bus.mem_wren !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wren_busy: got wren=%b busy=%b expected 0 0", bus.mem_wren, bus.busy);
    end
    n_checks++;
    if (bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0 ||
        bus.if_rsp_data !== 32'd0 || bus.ls_rsp_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rsp: got ifv=%b lsv=%b ifd=%h lsd=%h expected all 0",
               bus.if_rsp_valid, bus.ls_rsp_valid, bus.if_rsp_data, bus.ls_rsp_data);
    end
    n_checks++;
    if (bus.mem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr);
    end
    drive_idle();
    step();
    rst = 1'b0;
    mem_init = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'd0;
    @(negedge clk);
    n_checks++;
    if (bus.if_req_ready !== 1'b1 || bus.ls_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_ready: got if=%b ls=%b expected 1 0", bus.if_req_ready, bus.ls_req_ready);
    end
    step();
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.mem_addr !== 32'd0 || bus.mem_wren !== 1'b0 ||
        bus.mem_funct3 !== WORD) begin
      n_fail++;
      $display("FAIL fetch_issue: got busy=%b addr=%h wren=%b f3=%0d expected 1 0 0 %0d",
               bus.busy, bus.mem_addr, bus.mem_wren, bus.mem_funct3, WORD);
    end
    n_checks++;
    if (bus.if_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_early_rsp: got %b expected 0", bus.if_rsp_valid);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== 32'd12345 || bus.ls_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_rsp: got v=%b d=%0d lsv=%b expected 1 12345 0",
               bus.if_rsp_valid, bus.if_rsp_data, bus.ls_rsp_valid);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.if_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_done: got busy=%b v=%b expected 0 0", bus.busy, bus.if_rsp_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    req_id_e exp [4];
    req_id_e got [4];
    int      gcyc [4];
    int      g;
    bit      both;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    exp = '{REQ_LS, REQ_IF, REQ_LS, REQ_IF};
`else
    exp = '{REQ_LS, REQ_LS, REQ_LS, REQ_LS};
`endif
    g    = 0;
    both = 1'b0;
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'd0;
    bus.ls_req_valid = 1'b1;
    bus.ls_addr      = 32'd0;
    for (int c = 0; c < 40 && g < 4; c++) begin
      @(negedge clk);
      if (bus.if_req_ready && bus.ls_req_ready) both = 1'b1;
      if (bus.ls_req_ready) begin
        got[g] = REQ_LS; gcyc[g] = c; g++;
      end else if (bus.if_req_ready) begin
        got[g] = REQ_IF; gcyc[g] = c; g++;
      end
    end
    step();
    drive_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    step();
    n_checks++;
    if (g != 4) begin
      n_fail++;
      $display("FAIL b2b_grant_count: got %0d expected 4", g);
    end
    for (int i = 0; i < g; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: got %0d expected %0d", i, got[i], exp[i]);
      end
    end
    for (int i = 1; i < g; i++) begin
      n_checks++;
      if (gcyc[i] - gcyc[i-1] != 3) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: got %0d expected 3", i, gcyc[i] - gcyc[i-1]);
      end
    end
    n_checks++;
    if (both !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_both_ready: got %b expected 0", both);
    end
  endtask

  task automatic test_store_load();
    int          wcnt, rcnt, rk;
    logic [31:0] rdat, waddr, wdat, rd;
    bit          ok;
    wcnt = 0; rcnt = 0; rk = -1; rdat = 'x; waddr = 'x; wdat = 'x;
    bus.ls_req_valid = 1'b1;
    bus.ls_addr      = 32'd8;
    bus.ls_wren      = 1'b1;
    bus.ls_wr_data   = 32'd101010;
    bus.ls_funct3    = WORD;
    @(negedge clk);
    n_checks++;
    if (bus.ls_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL store_ready: got %b expected 1", bus.ls_req_ready);
    end
    step();
    drive_idle();
    bus.ls_wr_data = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.mem_wren === 1'b1) begin
        wcnt++; waddr = bus.mem_addr; wdat = bus.mem_wr_data;
      end
      if (bus.ls_rsp_valid === 1'b1) begin
        rcnt++; rk = k; rdat = bus.ls_rsp_data;
      end
    end
    step();
    n_checks++;
    if (wcnt != 1 || waddr !== 32'd8 || wdat !== 32'd101010) begin
      n_fail++;
      $display("FAIL store_wren: got cycles=%0d addr=%h data=%0d expected 1 8 101010", wcnt, waddr, wdat);
    end
    n_checks++;
    if (rcnt != 1 || rk != 1 || rdat !== 32'd0) begin
      n_fail++;
      $display("FAIL store_ack: got pulses=%0d at=%0d data=%h expected 1 1 0", rcnt, rk, rdat);
    end
    ls_txn(32'd8, 1'b0, 32'd0, WORD, rd, ok);
    n_checks++;
    if (ok !== 1'b1 || rd !== 32'd101010) begin
      n_fail++;
      $display("FAIL load_after_store: got ok=%b data=%0d expected 1 101010", ok, rd);
    end
  endtask

  task automatic test_busy_hold();
    bus.ls_req_valid = 1'b1;
    bus.ls_addr      = 32'd0;
    bus.ls_wren      = 1'b0;
    step();
    drive_idle();
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'd8;
    @(negedge clk);
    n_checks++;
    if (bus.if_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ready_issue: got %b expected 0", bus.if_req_ready);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.if_req_ready !== 1'b0 || bus.ls_rsp_valid !== 1'b1 || bus.ls_rsp_data !== 32'd12345) begin
      n_fail++;
      $display("FAIL hold_resp: got ifrdy=%b lsv=%b lsd=%0d expected 0 1 12345",
               bus.if_req_ready, bus.ls_rsp_valid, bus.ls_rsp_data);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.if_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ready_idle: got %b expected 1", bus.if_req_ready);
    end
    step();
    bus.if_req_valid = 1'b0;
    bus.if_addr      = 32'hFC;
    @(negedge clk);
    n_checks++;
    if (bus.mem_addr !== 32'd8 || bus.mem_funct3 !== WORD || bus.mem_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_issue: got addr=%h f3=%0d wren=%b expected 8 %0d 0",
               bus.mem_addr, bus.mem_funct3, bus.mem_wren, WORD);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== 32'd101010) begin
      n_fail++;
      $display("FAIL hold_rsp: got v=%b d=%0d expected 1 101010", bus.if_rsp_valid, bus.if_rsp_data);
    end
    drive_idle();
    step();
  endtask

  task automatic test_reset_store();
    int          pulses;
    logic [31:0] rd;
    bit          ok;
    pulses = 0;
    bus.ls_req_valid = 1'b1;
    bus.ls_addr      = 32'd12;
    bus.ls_wren      = 1'b1;
    bus.ls_wr_data   = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (bus.ls_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rststore_ready: got %b expected 1", bus.ls_req_ready);
    end
    step();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL rststore_wren: got %b expected 0", bus.mem_wren);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ls_rsp_valid !== 1'b0 || bus.ls_rsp_data !== 32'd0 ||
        bus.mem_addr !== 32'd0 || bus.mem_wren !== 1'b0 || bus.ls_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rststore_outputs: got busy=%b v=%b d=%h addr=%h wren=%b rdy=%b expected all 0",
               bus.busy, bus.ls_rsp_valid, bus.ls_rsp_data, bus.mem_addr, bus.mem_wren, bus.ls_req_ready);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.ls_rsp_valid === 1'b1) pulses++;
    end
    step();
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL rststore_no_rsp: got %0d pulses expected 0", pulses);
    end
    ls_txn(32'd12, 1'b0, 32'd0, WORD, rd, ok);
    n_checks++;
    if (ok !== 1'b1 || rd !== 32'h1111_2222) begin
      n_fail++;
      $display("FAIL rststore_prior: got ok=%b data=%h expected 1 11112222", ok, rd);
    end
  endtask

  task automatic test_byte();
    bus.ls_req_valid = 1'b1;
    bus.ls_addr      = 32'd5;
    bus.ls_wren      = 1'b0;
    bus.ls_funct3    = BYTE;
    step();
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (bus.mem_funct3 !== BYTE || bus.mem_addr !== 32'd5 || bus.mem_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_issue: got f3=%0d addr=%h wren=%b expected %0d 5 0",
               bus.mem_funct3, bus.mem_addr, bus.mem_wren, BYTE);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.ls_rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_rsp: got %b expected 1", bus.ls_rsp_valid);
    end
    step();
    step();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_fetch();
    test_back_to_back();
    test_store_load();
    test_busy_hold();
    test_reset_store();
    test_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
